// File: rtl/prog_sequencer_if.sv
// prog_sequencer_if: loader, imem and datapath signals
// of the microcode sequencer, grouped by direction.
interface prog_sequencer_if #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
);
  logic               load_start;
  logic               load_valid;
  logic [INSTR_W-1:0] load_data;
  logic               load_done;
  logic               load_ready;
  logic               run_start;
  logic               abort;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic [INSTR_W-1:0] imem_rdata;
  logic               zero_flag;
  logic               ext_ack;
  logic               exec_valid;
  logic [3:0]         exec_op;
  logic [3:0]         exec_arg;
  logic [ADDR_W-1:0]  pc;
  logic               busy;
  logic               halted;

  modport master (
    input  load_start, load_valid, load_data, load_done,
    input  run_start, abort, imem_rdata, zero_flag, ext_ack,
    output load_ready, imem_we, imem_addr, imem_wdata,
    output exec_valid, exec_op, exec_arg, pc, busy, halted
  );

  modport slave (
    output load_start, load_valid, load_data, load_done,
    output run_start, abort, imem_rdata, zero_flag, ext_ack,
    input  load_ready, imem_we, imem_addr, imem_wdata,
    input  exec_valid, exec_op, exec_arg, pc, busy, halted
  );
endinterface

// File: rtl/prog_sequencer.sv
// prog_sequencer: load / fetch / decode / execute control
// for the 4-bit microcode processor.
module prog_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
) (
  input logic              clk,
  input logic              rst,
  prog_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT,
    S_HALT
  } state_t;

  localparam logic [ADDR_W:0] DEPTH =
    {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] W_LAST =
    {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W-1:0] PC_LAST =
    {ADDR_W{1'b1}};

  state_t             state, state_n;
  logic [ADDR_W-1:0]  pc_q, pc_n;
  logic [ADDR_W:0]    waddr, waddr_n;
  logic [INSTR_W-1:0] ir, ir_n;
  logic               ev_q, ev_n;
  logic [3:0]         op_q, op_n;
  logic [3:0]         arg_q, arg_n;

  logic [3:0]         op, arg, rd_op;
  logic               ready, wr;
  logic               is_jmp, is_jz;
  logic               is_wait, is_halt;
  state_t             adv_state;
  logic [ADDR_W-1:0]  adv_pc;

  // Instruction fields, load handshake and the
  // sequential-advance target (no wrap past the top).
  always_comb begin
    op      = ir[INSTR_W-1 -: 4];
    arg     = ir[3:0];
    rd_op   = bus.imem_rdata[INSTR_W-1 -: 4];
    ready   = (state == S_LOAD) && (waddr < DEPTH);
    wr      = ready && bus.load_valid && !bus.abort;
    is_jmp  = (op == 4'hC);
    is_jz   = (op == 4'hD);
    is_wait = (op == 4'hE);
    is_halt = (op == 4'hF);
    if (pc_q == PC_LAST) begin
      adv_state = S_HALT;
      adv_pc    = pc_q;
    end else begin
      adv_state = S_FETCH;
      adv_pc    = pc_q + 1'b1;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    waddr_n = waddr;
    ir_n    = ir;
    ev_n    = 1'b0;
    op_n    = op_q;
    arg_n   = arg_q;
    if (bus.abort) begin
      state_n = S_IDLE;
      pc_n    = '0;
      waddr_n = '0;
    end else begin
      unique case (state)
        S_IDLE, S_HALT: begin
          if (bus.load_start) begin
            state_n = S_LOAD;
            waddr_n = '0;
          end else if (bus.run_start) begin
            state_n = S_FETCH;
            pc_n    = '0;
          end
        end
        S_LOAD: begin
          if (wr)
            waddr_n = waddr + 1'b1;
          if (bus.load_done || !ready ||
              (wr && waddr == W_LAST))
            state_n = S_IDLE;
        end
        S_FETCH: state_n = S_DECODE;
        S_DECODE: begin
          ir_n    = bus.imem_rdata;
          state_n = S_EXEC;
          if (rd_op >= 4'h1 && rd_op <= 4'hB) begin
            ev_n  = 1'b1;
            op_n  = rd_op;
            arg_n = bus.imem_rdata[3:0];
          end
        end
        S_EXEC: begin
          unique case (1'b1)
            is_jmp || (is_jz && bus.zero_flag): begin
              state_n = S_FETCH;
              pc_n    = ADDR_W'(arg);
            end
            is_wait: state_n = S_WAIT;
            is_halt: state_n = S_HALT;
            default: begin
              state_n = adv_state;
              pc_n    = adv_pc;
            end
          endcase
        end
        S_WAIT: begin
          if (bus.ext_ack) begin
            state_n = adv_state;
            pc_n    = adv_pc;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State, pc, write address and datapath strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc_q  <= '0;
      waddr <= '0;
      ir    <= '0;
      ev_q  <= 1'b0;
      op_q  <= '0;
      arg_q <= '0;
    end else begin
      state <= state_n;
      pc_q  <= pc_n;
      waddr <= waddr_n;
      ir    <= ir_n;
      ev_q  <= ev_n;
      op_q  <= op_n;
      arg_q <= arg_n;
    end
  end

  assign bus.load_ready = ready;
  assign bus.imem_we    = wr;
  assign bus.imem_addr  = (state == S_LOAD) ?
                          waddr[ADDR_W-1:0] : pc_q;
  assign bus.imem_wdata = wr ? bus.load_data : '0;
  assign bus.exec_valid = ev_q;
  assign bus.exec_op    = op_q;
  assign bus.exec_arg   = arg_q;
  assign bus.pc         = pc_q;
  assign bus.busy       = (state != S_IDLE) &&
                          (state != S_HALT);
  assign bus.halted     = (state == S_HALT);

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: random programs run against an
// instruction-level interpreter of the sequencer.
module tb_prog_sequencer;

  localparam int LIM = 150;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_sequencer_if bus ();

  prog_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (bus.imem_we)
      mem[bus.imem_addr] <= bus.imem_wdata;
    bus.imem_rdata <= mem[bus.imem_addr];
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] prog [16];
  logic [7:0] model_mem [16];
  logic [3:0] m_op, m_arg;

  logic [3:0] e_pc  [200];
  logic [3:0] e_op  [200];
  logic [3:0] e_arg [200];
  bit         e_ev  [200];
  bit         e_busy[200];
  bit         e_halt[200];
  bit         zf    [200];
  bit         ack   [200];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int c, input logic [3:0] p,
                      input bit ev, input bit halt);
    e_pc[c]   = p;
    e_ev[c]   = ev;
    e_op[c]   = m_op;
    e_arg[c]  = m_arg;
    e_busy[c] = !halt;
    e_halt[c] = halt;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pc"},   bus.pc, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_halt"}, bus.halted, 0);
    check({tag, "_ev"},   bus.exec_valid, 0);
    check({tag, "_op"},   bus.exec_op, 0);
    check({tag, "_arg"},  bus.exec_arg, 0);
    check({tag, "_rdy"},  bus.load_ready, 0);
    check({tag, "_we"},   bus.imem_we, 0);
    check({tag, "_wd"},   bus.imem_wdata, 0);
  endtask

  task automatic load_words(input int n, input bit early,
                            input bit gaps);
    @(negedge clk);
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.load_valid = 1'b0;
        bus.run_start  = 1'b1;
        #1;
        check("ld_gap_we", bus.imem_we, 0);
        check("ld_gap_rdy", bus.load_ready, 1);
        @(negedge clk);
        bus.run_start = 1'b0;
      end
      bus.load_valid = 1'b1;
      bus.load_data  = prog[i];
      bus.load_done  = early && (i == n - 1);
      #1;
      check("ld_we", bus.imem_we, 1);
      check("ld_addr", bus.imem_addr, i);
      check("ld_wdata", bus.imem_wdata, prog[i]);
      check("ld_rdy", bus.load_ready, 1);
      model_mem[i] = prog[i];
      @(negedge clk);
    end
    bus.load_done  = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h5A;
    #1;
    check("ld_rdy_off", bus.load_ready, 0);
    check("ld_we_off", bus.imem_we, 0);
    check("ld_busy_off", bus.busy, 0);
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask

  task automatic run_prog(input int zmode, input int wait_d);
    int c, hc, d, ncyc;
    bit done;
    logic [3:0] p, op, arg;
    logic [7:0] ins;
    for (int k = 0; k < 200; k++) begin
      zf[k]  = (zmode == 2) ? bit'($urandom_range(0, 1))
                            : bit'(zmode);
      ack[k] = ($urandom_range(0, 3) == 0);
    end
    c = 0; hc = 0; p = 0; done = 0;
    while (!done && c < LIM) begin
      ins = model_mem[p];
      op  = ins[7:4];
      arg = ins[3:0];
      fill(c, p, 0, 0);
      fill(c + 1, p, 0, 0);
      if (op >= 1 && op <= 11 && c + 2 <= LIM) begin
        m_op  = op;
        m_arg = arg;
      end
      fill(c + 2, p, (op >= 1 && op <= 11), 0);
      c += 3;
      if (op == 12 || (op == 13 && zf[c - 1])) begin
        p = arg;
      end else if (op == 15) begin
        hc = c; done = 1;
      end else begin
        if (op == 14) begin
          d = (wait_d != 0) ? wait_d : $urandom_range(1, 6);
          for (int k = 0; k < d; k++) begin
            fill(c + k, p, 0, 0);
            ack[c + k] = (k == d - 1);
          end
          c += d;
        end
        if (p == 4'd15) begin
          hc = c; done = 1;
        end else begin
          p = p + 1'b1;
        end
      end
    end
    if (done) begin
      for (int k = 0; k < 3; k++)
        fill(hc + k, p, 0, 1);
      ncyc = hc + 3;
    end else begin
      ncyc = LIM;
    end
    @(negedge clk);
    bus.run_start = 1'b1;
    @(negedge clk);
    bus.run_start = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      bus.zero_flag = zf[k];
      bus.ext_ack   = ack[k];
      #1;
      check("run_pc", bus.pc, e_pc[k]);
      check("run_ev", bus.exec_valid, e_ev[k]);
      check("run_op", bus.exec_op, e_op[k]);
      check("run_arg", bus.exec_arg, e_arg[k]);
      check("run_busy", bus.busy, e_busy[k]);
      check("run_halt", bus.halted, e_halt[k]);
      check("run_we", bus.imem_we, 0);
      @(negedge clk);
    end
    bus.ext_ack = 1'b0;
    if (!done) begin
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      #1;
      check("abort_busy", bus.busy, 0);
      check("abort_pc", bus.pc, 0);
      check("abort_halt", bus.halted, 0);
      check("abort_ev", bus.exec_valid, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.load_start = 0; bus.load_valid = 0;
    bus.load_data  = 0; bus.load_done  = 0;
    bus.run_start  = 0; bus.abort      = 0;
    bus.zero_flag  = 0; bus.ext_ack    = 0;
    m_op = 0; m_arg = 0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    #12;
    check_zero("rst");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) prog[i] = 8'h10 + 8'(i);
    load_words(16, 0, 0);

    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
    load_words(3, 1, 0);
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    load_words(16, 0, 1);

    prog[0] = 8'h13; prog[1] = 8'h25; prog[2] = 8'hF0;
    load_words(3, 1, 1);
    run_prog(2, 0);

    prog[0] = 8'hD4; prog[1] = 8'h00; prog[2] = 8'h00;
    prog[3] = 8'h00; prog[4] = 8'h31; prog[5] = 8'hC0;
    load_words(6, 1, 0);
    run_prog(0, 0);
    run_prog(1, 0);

    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    load_words(16, 0, 0);
    run_prog(2, 0);

    prog[0] = 8'hE0; prog[1] = 8'hF0;
    load_words(2, 1, 0);
    run_prog(2, 10);

    repeat (6) begin
      for (int i = 0; i < 16; i++)
        prog[i] = 8'($urandom);
      load_words(16, 0, 1);
      run_prog(2, 0);
    end

    prog[0] = 8'h37; prog[1] = 8'hE0; prog[2] = 8'hF0;
    load_words(3, 1, 0);
    @(negedge clk);
    bus.run_start = 1'b1;
    @(negedge clk);
    bus.run_start = 1'b0;
    bus.ext_ack   = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    check("wait_busy", bus.busy, 1);
    check("wait_pc", bus.pc, 1);
    check("wait_op", bus.exec_op, 3);
    #1;
    rst = 1'b1;
    #1;
    check_zero("arst");
    m_op = 0; m_arg = 0;
    @(negedge clk);
    rst = 1'b0;
    bus.ext_ack = 1'b1;
    @(negedge clk);
    bus.ext_ack = 1'b0;
    #1;
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_pc", bus.pc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
